// File: rtl/path_delay_tester_pkg.sv
// Shared types and width helpers for the launch/capture path tester.
package path_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PRE,
    LAUNCH,
    CAPT,
    DONE
  } state_t;

  // Widest INV_MASK the parity helper accepts.
  localparam int unsigned MAX_DEPTH = 64;

  // XOR-reduction of the stage mask: 1 when an odd number of stages invert.
  function automatic logic parity(input logic [MAX_DEPTH-1:0] mask);
    return ^mask;
  endfunction

  // Channel index width; never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Stage index width; one value past the last stage stays representable so
  // an out-of-range selection simply matches no stage.
  function automatic int unsigned stage_idx_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Phase counter width: holds 0..n without wrapping.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/path_delay_tester_if.sv
// Control/result bundle between the test sequencer and its host.
interface path_delay_tester_if
  import path_test_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 8
);
  localparam int unsigned CH_W  = ch_idx_w(CHANNELS);
  localparam int unsigned STG_W = stage_idx_w(DEPTH);

  logic                start;
  logic [CHANNELS-1:0] launch_val;
  logic                fault_en;
  logic [CH_W-1:0]     fault_ch;
  logic [STG_W-1:0]    fault_stage;
  logic                fault_sa;
  logic                busy;
  logic                done;
  logic                pass;
  logic [CHANNELS-1:0] fail_vec;
  logic [CHANNELS-1:0] capture;

  modport master (
    output start, launch_val, fault_en, fault_ch, fault_stage, fault_sa,
    input  busy, done, pass, fail_vec, capture
  );

  modport slave (
    input  start, launch_val, fault_en, fault_ch, fault_stage, fault_sa,
    output busy, done, pass, fail_vec, capture
  );
endinterface

// File: rtl/path_delay_tester_stage_chain.sv
// One channel's registered path: DEPTH stages, each buffering or inverting,
// with an optional stuck-at override on a single stage output.
module path_stage_chain #(
  parameter int unsigned     DEPTH    = 8,
  parameter logic [DEPTH-1:0] INV_MASK = '0,
  parameter int unsigned     STG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drive,
  input  logic             force_en,
  input  logic [STG_W-1:0] force_stage,
  input  logic             force_val,
  output logic             out_val
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_out;

  // Stage outputs as seen downstream, with the stuck-at override applied.
  always_comb begin
    stage_out = stage_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (force_en && (force_stage == STG_W'(k))) begin
        stage_out[k] = force_val;
      end
    end
  end

  // Shift the path one stage per clock, applying each stage's polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= drive ^ INV_MASK[0];
      for (int unsigned k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_out[k-1] ^ INV_MASK[k];
      end
    end
  end

  assign out_val = stage_out[DEPTH-1];

endmodule

// File: rtl/path_delay_tester.sv
// Launch/capture sequencer for CHANNELS parallel registered paths.
module path_delay_tester
  import path_test_pkg::*;
#(
  parameter int unsigned      CHANNELS = 4,
  parameter int unsigned      DEPTH    = 8,
  parameter logic [DEPTH-1:0] INV_MASK = 8'b1010_0111
) (
  input  logic                clk,
  input  logic                rst,
  path_delay_tester_if.slave  bus
);

  localparam int unsigned CH_W   = ch_idx_w(CHANNELS);
  localparam int unsigned STG_W  = stage_idx_w(DEPTH);
  localparam int unsigned CNT_W  = cnt_w(DEPTH);
  localparam logic        PAR    = parity(MAX_DEPTH'(INV_MASK));
  localparam int unsigned INIT_LOAD   = DEPTH - 1;
  localparam int unsigned LAUNCH_LOAD = (DEPTH > 1) ? DEPTH - 2 : 0;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CHANNELS-1:0] launch_q;
  logic                fault_en_q;
  logic [CH_W-1:0]     fault_ch_q;
  logic [STG_W-1:0]    fault_stage_q;
  logic                fault_sa_q;
  logic [CHANNELS-1:0] pre_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [CHANNELS-1:0] fail_q;
  logic [CHANNELS-1:0] capture_q;

  logic [CHANNELS-1:0] drive_vec;
  logic [CHANNELS-1:0] path_out;
  logic [CHANNELS-1:0] exp_vec;
  logic [CHANNELS-1:0] fail_now;
  logic                fault_live;

  // Path drive, expected capture and per-channel verdict.
  always_comb begin
    drive_vec  = (state == INIT) ? ~launch_q : launch_q;
    exp_vec    = launch_q ^ {CHANNELS{PAR}};
    fail_now   = (pre_q ^ ~exp_vec) | (capture_q ^ exp_vec);
    fault_live = fault_en_q && (state inside {INIT, PRE, LAUNCH, CAPT});
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    path_stage_chain #(
      .DEPTH    (DEPTH),
      .INV_MASK (INV_MASK),
      .STG_W    (STG_W)
    ) u_chain (
      .clk         (clk),
      .rst         (rst),
      .drive       (drive_vec[c]),
      .force_en    (fault_live && (fault_ch_q == CH_W'(c))),
      .force_stage (fault_stage_q),
      .force_val   (fault_sa_q),
      .out_val     (path_out[c])
    );
  end

  // Sequencer: flush, launch, capture, judge; all outputs registered.
  // Verdict is registered in DONE, so done and the final busy cycle land one
  // clock later in IDLE, where start is still refused while busy is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      launch_q      <= '0;
      fault_en_q    <= 1'b0;
      fault_ch_q    <= '0;
      fault_stage_q <= '0;
      fault_sa_q    <= 1'b0;
      pre_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= '0;
      capture_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.start && !busy_q) begin
            launch_q      <= bus.launch_val;
            fault_en_q    <= bus.fault_en;
            fault_ch_q    <= bus.fault_ch;
            fault_stage_q <= bus.fault_stage;
            fault_sa_q    <= bus.fault_sa;
            busy_q        <= 1'b1;
            pass_q        <= 1'b0;
            fail_q        <= '0;
            capture_q     <= '0;
            cnt           <= CNT_W'(INIT_LOAD);
            state         <= INIT;
          end
        end
        INIT: begin
          if (cnt == '0) state <= PRE;
          else           cnt   <= cnt - 1'b1;
        end
        PRE: begin
          pre_q <= path_out;
          cnt   <= CNT_W'(LAUNCH_LOAD);
          state <= (DEPTH == 1) ? CAPT : LAUNCH;
        end
        LAUNCH: begin
          if (cnt == '0) state <= CAPT;
          else           cnt   <= cnt - 1'b1;
        end
        CAPT: begin
          capture_q <= path_out;
          state     <= DONE;
        end
        DONE: begin
          fail_q <= fail_now;
          pass_q <= ~|fail_now;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail_vec = fail_q;
  assign bus.capture  = capture_q;

endmodule

// File: tb/tb_path_delay_tester.sv
// Randomised and directed checks of the path tester against a path-level model.
module tb_path_delay_tester;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DEPTH    = 8;
  localparam logic [7:0]  INV_MASK = 8'b1010_0111;
  localparam int          LATENCY  = 2 * DEPTH + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  path_delay_tester_if #(.CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus ();

  path_delay_tester #(
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH),
    .INV_MASK (INV_MASK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Path model: an unfaulted path ends at launch xor overall mask parity; a
  // stuck stage pins the output to sa xor parity of the stages after it, so
  // pre and capture agree and that channel necessarily fails.
  function automatic logic mask_parity_from(input int first);
    logic [7:0] m;
    m = INV_MASK;
    return logic'($countones(m >> first) % 2);
  endfunction

  task automatic clear_inputs();
    bus.start       = 1'b0;
    bus.launch_val  = '0;
    bus.fault_en    = 1'b0;
    bus.fault_ch    = '0;
    bus.fault_stage = '0;
    bus.fault_sa    = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_pass"}, 32'(bus.pass), 0);
    check({tag, "_fail"}, 32'(bus.fail_vec), 0);
    check({tag, "_cap"},  32'(bus.capture), 0);
  endtask

  task automatic run_test(input string tag, input logic [3:0] lv, input logic fen,
                          input logic [1:0] fch, input logic [3:0] fstg,
                          input logic fsa, input bit dbl);
    logic [3:0] exp_cap;
    logic [3:0] exp_fail;
    int stg;
    int k;
    int done_at;
    int pulses;
    stg      = int'(fstg);
    exp_cap  = lv ^ {4{mask_parity_from(0)}};
    exp_fail = '0;
    if (fen && stg < int'(DEPTH)) begin
      exp_fail[fch] = 1'b1;
      exp_cap[fch]  = fsa ^ mask_parity_from(stg + 1);
    end

    bus.launch_val  = lv;
    bus.fault_en    = fen;
    bus.fault_ch    = fch;
    bus.fault_stage = fstg;
    bus.fault_sa    = fsa;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.launch_val  = 4'($urandom);
    bus.fault_en    = 1'($urandom);
    bus.fault_ch    = 2'($urandom);
    bus.fault_stage = 4'($urandom);
    bus.fault_sa    = 1'($urandom);
    k = 1;
    check({tag, "_busy_t1"}, 32'(bus.busy), 1);
    check({tag, "_pass_clr"}, 32'(bus.pass), 0);
    check({tag, "_cap_clr"}, 32'(bus.capture), 0);
    check({tag, "_fail_clr"}, 32'(bus.fail_vec), 0);

    done_at = 0;
    pulses  = 0;
    while (k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (dbl && k == 5) bus.start = 1'b1;
      if (dbl && k == 6) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        if (done_at == 0) done_at = k;
        check({tag, "_cap"},  32'(bus.capture),  32'(exp_cap));
        check({tag, "_fail"}, 32'(bus.fail_vec), 32'(exp_fail));
        check({tag, "_pass"}, 32'(bus.pass),     32'(exp_fail == '0));
      end
      if (k == LATENCY)     check({tag, "_busy_last"}, 32'(bus.busy), 1);
      if (k == LATENCY + 1) check({tag, "_busy_drop"}, 32'(bus.busy), 0);
    end
    check({tag, "_done_at"}, 32'(done_at), 32'(LATENCY));
    check({tag, "_pulses"},  32'(pulses), 1);
    check({tag, "_cap_hold"}, 32'(bus.capture), 32'(exp_cap));
  endtask

  initial begin
    int k;
    int pulses;
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst_hold");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero("rst_rel");

    run_test("basic",  4'b1010, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    run_test("fault",  4'b1010, 1'b1, 2'd2, 4'd3, 1'b1, 1'b0);
    run_test("oor",    4'b1111, 1'b1, 2'd2, 4'd9, 1'b1, 1'b0);
    run_test("dblst",  4'b0110, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    run_test("last",   4'b0001, 1'b1, 2'd0, 4'd7, 1'b0, 1'b0);
    run_test("first",  4'b1000, 1'b1, 2'd3, 4'd0, 1'b1, 1'b0);

    // Reset in the middle of a run.
    bus.launch_val = 4'b1010;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 1;
    while (k < 9) begin
      @(posedge clk);
      #1;
      k++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs_zero("midrst");
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    check("midrst_nodone", 32'(pulses), 0);
    run_test("after_rst", 4'b1010, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_test($sformatf("rnd%0d", i), 4'($urandom), 1'($urandom),
               2'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
